vend_machine_multi: RTL

- Parametrised multi-product vending controller, successor to the single-product drink FSM.
- Accumulates coin credit (1 unit = 5), vends a selected product whose price comes from a per-product parameter table, then returns any remaining credit as serial change.
- Adds saturation/reject of overpayment and a busy indication.
- Sits between the coin/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vend_machine_multi_if.sv | 64 ++++++
 rtl/vend_machine_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vend_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vend_machine_multi_if
//
// Bundles the vending controller's front-end and driver-side signals so that
// the controller and whatever drives it share one connection.
//
// Signals:
//   coin       front end -> controller  0 none, 1 one unit, 2 two units,
//                                        3 refund request
//   sel        front end -> controller  product index
//   sel_valid  front end -> controller  purchase request
//   drink      controller -> driver      one-cycle vend pulse
//   drink_id   controller -> driver      product index of the vend
//   back       controller -> driver      change coin: 0 none, 1 one, 2 two
//   reject     controller -> front end   previous coin was refused
//   busy       controller -> front end   change is being paid out
//   credit     controller -> front end   current credit in units
//
// Modports:
//   master  the coin/keypad side (drives requests, observes results)
//   slave   the controller itself
// ---------------------------------------------------------------------------
interface vend_machine_multi_if #(
  parameter int SEL_W    = 2,
  parameter int CREDIT_W = 5
);

  logic [1:0]          coin;
  logic [SEL_W-1:0]    sel;
  logic                sel_valid;
  logic                drink;
  logic [SEL_W-1:0]    drink_id;
  logic [1:0]          back;
  logic                reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  // Request side: owns the coin and keypad inputs, watches every result.
  modport master (
    output coin,
    output sel,
    output sel_valid,
    input  drink,
    input  drink_id,
    input  back,
    input  reject,
    input  busy,
    input  credit
  );

  // Controller side: samples requests, drives every registered output.
  modport slave (
    input  coin,
    input  sel,
    input  sel_valid,
    output drink,
    output drink_id,
    output back,
    output reject,
    output busy,
    output credit
  );

endinterface

// File: rtl/vend_machine_multi.sv
// ---------------------------------------------------------------------------
// vend_machine_multi
//
// Multi-product vending controller. Accumulates coin credit in units of 5,
// vends the selected product when the credit covers its price (prices come
// from the packed PRICES table), then pays any leftover credit back as a
// serial stream of change coins. Overpayment beyond MAX_CREDIT is refused
// with a one-cycle reject pulse. All outputs are registered.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous reset, active low
//   bus     vend_machine_multi_if.slave
//             in : coin, sel, sel_valid
//             out: drink, drink_id, back, reject, busy, credit
//
// Parameters:
//   N_PROD      number of products (1..2^SEL_W)
//   SEL_W       width of the product select
//   CREDIT_W    width of the credit register and of each price entry
//   MAX_CREDIT  credit ceiling in units, below 2^CREDIT_W
//   PRICES      packed price table, product i at [i*CREDIT_W +: CREDIT_W]
// ---------------------------------------------------------------------------
module vend_machine_multi #(
  parameter int                         N_PROD     = 4,
  parameter int                         SEL_W      = 2,
  parameter int                         CREDIT_W   = 5,
  parameter int                         MAX_CREDIT = 20,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {5'd6, 5'd4, 5'd2, 5'd3}
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  vend_machine_multi_if.slave bus
);

  // The coin sum is formed one bit wider than the credit register so that an
  // overpayment is detected instead of wrapping around.
  localparam int SUM_W = CREDIT_W + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    CHANGE = 1'b1
  } state_t;

  state_t              state_q,   state_d;
  logic [CREDIT_W-1:0] credit_q,  credit_d;
  logic                drink_q,   drink_d;
  logic [SEL_W-1:0]    drinkId_q, drinkId_d;
  logic [1:0]          back_q,    back_d;
  logic                reject_q,  reject_d;
  logic                busy_q,    busy_d;

  logic                isCoin;
  logic                isRefund;
  logic [SUM_W-1:0]    coinUnits;
  logic [SUM_W-1:0]    coinSum;
  logic                coinOk;
  logic [CREDIT_W-1:0] effCredit;
  logic                selInRange;
  logic [CREDIT_W-1:0] priceSel;
  logic                canVend;
  logic [CREDIT_W-1:0] remainder;

  // Decode the coin input and work out the credit that a purchase on this
  // edge would see. A coin arriving together with a select counts toward the
  // purchase, so the "effective" credit already includes an accepted coin.
  always_comb begin
    isCoin    = (bus.coin == 2'd1) || (bus.coin == 2'd2);
    isRefund  = (bus.coin == 2'd3);
    coinUnits = '0;
    if (bus.coin == 2'd1) begin
      coinUnits = SUM_W'(1);
    end else if (bus.coin == 2'd2) begin
      coinUnits = SUM_W'(2);
    end
    coinSum   = {1'b0, credit_q} + coinUnits;
    coinOk    = isCoin && (coinSum <= SUM_W'(MAX_CREDIT));
    effCredit = coinOk ? coinSum[CREDIT_W-1:0] : credit_q;
  end

  // Look up the price of the selected product. Indices at or beyond N_PROD
  // have no table entry, so they are flagged out of range and never vend.
  always_comb begin
    selInRange = 1'b0;
    priceSel   = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (bus.sel == i[SEL_W-1:0]) begin
        selInRange = 1'b1;
        priceSel   = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    canVend   = bus.sel_valid && selInRange && (effCredit >= priceSel);
    remainder = effCredit - priceSel;
  end

  // Next-state and next-output logic. In IDLE a refund takes priority over
  // everything, then the coin is applied, then a purchase is attempted
  // against the coin-adjusted credit. In CHANGE the credit is drained two
  // units at a time, finishing with a single unit if the credit is odd, and
  // one idle cycle with no coin out precedes the return to IDLE. Coins
  // offered during CHANGE are refused and never credited.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    drink_d   = 1'b0;
    drinkId_d = drinkId_q;
    back_d    = 2'd0;
    reject_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (isRefund) begin
          if (credit_q != '0) begin
            state_d = CHANGE;
          end
        end else begin
          reject_d = isCoin && !coinOk;
          if (canVend) begin
            drink_d   = 1'b1;
            drinkId_d = bus.sel;
            credit_d  = remainder;
            if (remainder != '0) begin
              state_d = CHANGE;
            end
          end else begin
            credit_d = effCredit;
          end
        end
      end

      CHANGE: begin
        reject_d = isCoin;
        if (credit_q >= CREDIT_W'(2)) begin
          back_d   = 2'd2;
          credit_d = credit_q - CREDIT_W'(2);
        end else if (credit_q == CREDIT_W'(1)) begin
          back_d   = 2'd1;
          credit_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CHANGE);
  end

  // State and output registers. Reset is asynchronous so that pulling rst_ni
  // low clears credit and any change in progress without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      drink_q   <= 1'b0;
      drinkId_q <= '0;
      back_q    <= 2'd0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      drink_q   <= drink_d;
      drinkId_q <= drinkId_d;
      back_q    <= back_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
    end
  end

  // Every output comes straight from a register.
  assign bus.drink    = drink_q;
  assign bus.drink_id = drinkId_q;
  assign bus.back     = back_q;
  assign bus.reject   = reject_q;
  assign bus.busy     = busy_q;
  assign bus.credit   = credit_q;

endmodule
